// File: rtl/soma_sched_pkg.sv
// Shared types and constants for the soma event scheduler.
package soma_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_FIRE = 3'd2,
    ST_REFRACT   = 3'd3,
    ST_DEAD      = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_INTEG = 2'b01;
  localparam logic [1:0] OP_LEAK  = 2'b10;

  localparam int DROP_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer; the pointer moves past the winner only when update is asserted.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        winner     = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer advances to winner+1 after each accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (winner == PW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/soma_event_scheduler.sv
// Shares one soma datapath among NUM_REQ event sources: issues INTEG ops
// from arbitrated events, one LEAK per timestep, and enforces refractory.
module soma_event_scheduler
  import soma_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       kill,
  input  logic [7:0]                 refr_time,
  input  logic                       ts_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*W_WIDTH-1:0] req_weight,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       soma_valid,
  output logic [1:0]                 soma_op,
  output logic [W_WIDTH-1:0]         soma_weight,
  input  logic                       soma_fire,
  output logic                       refr_active,
  output logic                       dead,
  output logic [15:0]                drop_count
);

  state_t              state, state_nx;
  logic                leak_pending;
  logic [7:0]          refr_len;
  logic [7:0]          refr_cnt;
  logic [DROP_W-1:0]   drops;
  logic [NUM_REQ-1:0]  grant;
  logic                ready_en;
  logic                xfer;
  logic [W_WIDTH-1:0]  wt_sel;
  logic [1:0]          op_nx;
  logic [W_WIDTH-1:0]  wt_nx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .update (xfer),
    .grant  (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (leak_pending || xfer) state_nx = ST_ISSUE;
      ST_ISSUE:     state_nx = ST_WAIT_FIRE;
      ST_WAIT_FIRE: state_nx = (soma_fire && refr_len != 8'd0) ? ST_REFRACT : ST_IDLE;
      ST_REFRACT:   if (ts_tick && refr_cnt <= 8'd1) state_nx = ST_IDLE;
      ST_DEAD:      state_nx = ST_DEAD;
      default:      state_nx = ST_IDLE;
    endcase
    if (kill) state_nx = ST_DEAD;
  end

  // Accept handshake and the op that will be latched on entry to ISSUE.
  // A pending LEAK blocks acceptance so it gets the slot first.
  always_comb begin
    ready_en  = (state == ST_IDLE && !leak_pending) || (state == ST_REFRACT);
    req_ready = grant & {NUM_REQ{ready_en}};
    xfer      = |(req_valid & req_ready);
    wt_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) wt_sel = wt_sel | req_weight[i*W_WIDTH +: W_WIDTH];
    op_nx = OP_NOP;
    wt_nx = '0;
    if (state == ST_IDLE) begin
      if (leak_pending) begin
        op_nx = OP_LEAK;
      end else if (xfer) begin
        op_nx = OP_INTEG;
        wt_nx = wt_sel;
      end
    end
  end

  // Leak bookkeeping, refractory counter and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      leak_pending <= 1'b0;
      refr_cnt     <= 8'd0;
      drops        <= '0;
      refr_len     <= refr_time;
    end else begin
      // A fire starts a new refractory epoch, so any queued leak is dropped.
      if (state == ST_WAIT_FIRE && soma_fire)
        leak_pending <= 1'b0;
      else if (ts_tick && state != ST_REFRACT && state != ST_DEAD)
        leak_pending <= 1'b1;
      else if (state == ST_IDLE && leak_pending)
        leak_pending <= 1'b0;

      if (state == ST_WAIT_FIRE && soma_fire && refr_len != 8'd0)
        refr_cnt <= refr_len;
      else if (state == ST_REFRACT && ts_tick && refr_cnt != 8'd0)
        refr_cnt <= refr_cnt - 8'd1;

      if (state == ST_REFRACT && xfer && drops != {DROP_W{1'b1}})
        drops <= drops + 1'b1;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      soma_valid  <= 1'b0;
      soma_op     <= OP_NOP;
      soma_weight <= '0;
      refr_active <= 1'b0;
      dead        <= 1'b0;
    end else begin
      soma_valid  <= (state_nx == ST_ISSUE);
      soma_op     <= (state_nx == ST_ISSUE) ? op_nx : OP_NOP;
      soma_weight <= (state_nx == ST_ISSUE) ? wt_nx : '0;
      refr_active <= (state_nx == ST_REFRACT);
      dead        <= (state_nx == ST_DEAD);
    end
  end

  assign drop_count = drops;

endmodule

// File: tb/tb_soma_event_scheduler.sv
// Scoreboard bench for soma_event_scheduler: expected soma ops are queued
// when stimulus is driven and compared when soma_valid appears.
module tb_soma_event_scheduler;
  import soma_sched_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           kill;
  logic [7:0]     refr_time;
  logic           ts_tick;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_weight;
  logic [N-1:0]   req_ready;
  logic           soma_valid;
  logic [1:0]     soma_op;
  logic [W-1:0]   soma_weight;
  logic           soma_fire;
  logic           refr_active;
  logic           dead;
  logic [15:0]    drop_count;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] sb_q[$];   // {op, weight}

  soma_event_scheduler #(.NUM_REQ(N), .W_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .kill(kill), .refr_time(refr_time), .ts_tick(ts_tick),
    .req_valid(req_valid), .req_weight(req_weight), .req_ready(req_ready),
    .soma_valid(soma_valid), .soma_op(soma_op), .soma_weight(soma_weight),
    .soma_fire(soma_fire), .refr_active(refr_active), .dead(dead),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    kill = 1'b0; ts_tick = 1'b0; soma_fire = 1'b0; req_valid = '0;
  endtask

  task automatic do_reset(input logic [7:0] rt);
    idle_inputs();
    rst = 1'b1;
    refr_time = rt;
    step();
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  // Wait (bounded) for the next soma strobe and compare it with the queue head.
  task automatic sb_pop(output int lat);
    logic [W+1:0] exp;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (soma_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got op=%b w=%h, none queued", soma_op, soma_weight);
        end else begin
          exp = sb_q.pop_front();
          if ({soma_op, soma_weight} !== exp) begin
            bad++;
            $display("FAIL sb_op: got op=%b w=%h want op=%b w=%h",
                     soma_op, soma_weight, exp[W+1:W], exp[W-1:0]);
          end
        end
        return;
      end
    end
    total++; bad++;
    $display("FAIL sb_timeout: got no soma_valid in 20 cycles, want one");
  endtask

  task automatic expect_quiet(input int n, input string name);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (soma_valid) cnt++;
    end
    total++;
    if (cnt !== 0) begin
      bad++;
      $display("FAIL %s: got %0d strobes want 0", name, cnt);
    end
  endtask

  // Issue one event from requester 0, fire on it, and land in REFRACT.
  task automatic enter_refract(input logic [7:0] w);
    int lat;
    req_weight[7:0] = w;
    req_valid = 4'b0001;
    sb_q.push_back({OP_INTEG, w});
    step();
    req_valid = '0;
    sb_pop(lat);
    step();            // WAIT_FIRE
    soma_fire = 1'b1;
    step();            // first REFRACT cycle
    soma_fire = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    do_reset(8'd3);
    @(negedge clk);
    total++;
    if ({soma_valid, soma_op, soma_weight} !== '0) begin
      bad++; $display("FAIL rst_soma: got %b_%b_%h want 0", soma_valid, soma_op, soma_weight);
    end
    total++;
    if ({req_ready, refr_active, dead} !== '0) begin
      bad++; $display("FAIL rst_flags: got rdy=%b refr=%b dead=%b want 0", req_ready, refr_active, dead);
    end
    total++;
    if (drop_count !== 16'd0) begin
      bad++; $display("FAIL rst_drop: got %h want 0", drop_count);
    end
    step();
    req_weight[7:0] = 8'h12;
    req_valid = 4'b0001;
    sb_q.push_back({OP_INTEG, 8'h12});
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL rst_accept_ready: got %b want 0001", req_ready);
    end
    step();            // ISSUE, request still held
    sb_pop(lat);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL rst_latency: got %0d want 1", lat);
    end
    total++;
    if (req_ready !== 4'b0000) begin
      bad++; $display("FAIL rst_issue_ready: got %b want 0000", req_ready);
    end
    step();
    req_valid = '0;
    expect_quiet(3, "rst_no_repeat");
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset(8'd3);
    req_weight = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) sb_q.push_back({OP_INTEG, 8'h11 * 8'((i % 4) + 1)});
    for (int i = 0; i < 5; i++) begin
      sb_pop(lat);
      total++;
      if (lat !== ((i == 0) ? 2 : 3)) begin
        bad++; $display("FAIL rr_gap%0d: got %0d want %0d", i, lat, (i == 0) ? 2 : 3);
      end
    end
    step();
    req_valid = '0;
    expect_quiet(4, "rr_tail");
  endtask

  task automatic test_tick_event();
    int lat;
    do_reset(8'd3);
    req_weight[15:8] = 8'h5A;
    req_valid = 4'b0010;
    ts_tick = 1'b1;
    sb_q.push_back({OP_INTEG, 8'h5A});
    sb_q.push_back({OP_LEAK, 8'h00});
    step();
    ts_tick = 1'b0;
    req_valid = '0;
    sb_pop(lat);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL tick_integ_lat: got %0d want 1", lat);
    end
    sb_pop(lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL tick_leak_lat: got %0d want 3", lat);
    end
    expect_quiet(4, "tick_single_leak");
    // Two ticks while busy coalesce into one LEAK.
    step();
    req_weight[7:0] = 8'h77;
    req_valid = 4'b0001;
    sb_q.push_back({OP_INTEG, 8'h77});
    sb_q.push_back({OP_LEAK, 8'h00});
    step();            // ISSUE
    req_valid = '0;
    ts_tick = 1'b1;
    sb_pop(lat);
    step();            // WAIT_FIRE
    ts_tick = 1'b1;
    step();            // IDLE
    ts_tick = 1'b0;
    sb_pop(lat);
    total++;
    if (lat !== 2) begin
      bad++; $display("FAIL tick_coalesce_lat: got %0d want 2", lat);
    end
    expect_quiet(6, "tick_coalesce_single");
  endtask

  task automatic test_refractory();
    int lat;
    int strobes;
    do_reset(8'd3);
    enter_refract(8'h01);
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 5) ? 4'b0001 : 4'b0000;
      ts_tick = (c == 2 || c == 4 || c == 6);
      @(negedge clk);
      if (soma_valid) strobes++;
      total++;
      if (refr_active !== (c <= 6)) begin
        bad++; $display("FAIL refr_active_c%0d: got %b want %b", c, refr_active, c <= 6);
      end
      if (c == 7) begin
        total++;
        if (drop_count !== 16'd5) begin
          bad++; $display("FAIL refr_drops: got %0d want 5", drop_count);
        end
      end
      step();
    end
    total++;
    if (strobes !== 0) begin
      bad++; $display("FAIL refr_strobes: got %0d want 0", strobes);
    end
    idle_inputs();
    expect_quiet(5, "refr_exit_no_leak");
    // Zero-length refractory returns straight to IDLE.
    do_reset(8'd0);
    enter_refract(8'h02);
    req_weight[15:8] = 8'h5A;
    req_valid = 4'b0010;
    sb_q.push_back({OP_INTEG, 8'h5A});
    @(negedge clk);
    total++;
    if (refr_active !== 1'b0) begin
      bad++; $display("FAIL refr0_active: got %b want 0", refr_active);
    end
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL refr0_ready: got %b want 0010", req_ready);
    end
    sb_pop(lat);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL refr0_lat: got %0d want 1", lat);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_kill();
    int lat;
    do_reset(8'd3);
    req_weight[7:0] = 8'h33;
    req_valid = 4'b0001;
    sb_q.push_back({OP_INTEG, 8'h33});
    step();            // ISSUE
    req_valid = '0;
    kill = 1'b1;
    sb_pop(lat);
    total++;
    if (lat !== 1) begin
      bad++; $display("FAIL kill_strobe_lat: got %0d want 1", lat);
    end
    step();
    kill = 1'b0;
    req_valid = 4'b1111;
    ts_tick = 1'b1;
    soma_fire = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({dead, req_ready, soma_valid} !== {1'b1, 4'b0000, 1'b0}) begin
        bad++;
        $display("FAIL kill_dead_c%0d: got dead=%b rdy=%b sv=%b want 1 0000 0",
                 c, dead, req_ready, soma_valid);
      end
      step();
    end
    do_reset(8'd3);
    req_valid = 4'b0001;
    sb_q.push_back({OP_INTEG, 8'h33});
    @(negedge clk);
    total++;
    if ({dead, req_ready} !== {1'b0, 4'b0001}) begin
      bad++; $display("FAIL kill_rst: got dead=%b rdy=%b want 0 0001", dead, req_ready);
    end
    sb_pop(lat);
    step();
    req_valid = '0;
  endtask

  task automatic test_drop_saturation();
    do_reset(8'd3);
    enter_refract(8'h03);
    req_valid = 4'b1111;
    repeat (65534) step();
    @(negedge clk);
    total++;
    if (drop_count !== 16'hFFFE) begin
      bad++; $display("FAIL sat_near: got %h want fffe", drop_count);
    end
    repeat (10) step();
    @(negedge clk);
    total++;
    if (drop_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold: got %h want ffff", drop_count);
    end
    total++;
    if (refr_active !== 1'b1) begin
      bad++; $display("FAIL sat_refr: got %b want 1", refr_active);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    refr_time = 8'd0;
    req_weight = '0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_tick_event();
    test_refractory();
    test_kill();
    test_drop_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
